// File: rtl/ft245_echo_fifo.sv
// User-side echo engine for the FT245RL core: buffers RX bytes in a FIFO and
// replays them on the TX path in byte, line-buffered or inverted mode.
module ft245_echo_fifo #(
  parameter int                 DATA_W     = 8,
  parameter int                 DEPTH_LOG2 = 4,
  parameter logic [DATA_W-1:0]  TERM       = 8'h0D
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_DONE,
  input  logic [DATA_W-1:0]     RX_DATA,
  input  logic                  TX_VALID,
  input  logic                  TX_DONE,
  output logic                  TXEN,
  output logic [DATA_W-1:0]     TX_DATA,
  input  logic [1:0]            MODE,
  input  logic                  CLR_OVF,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  BUSY
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} txState_t;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [DEPTH_LOG2:0]   count, lineCnt;
  logic                  flush;
  logic                  overflow;
  logic                  txEn;
  logic [DATA_W-1:0]     txData;
  txState_t              state;

  logic                  full, empty, eligible, push, pop, pushTerm, popTerm;
  logic [DATA_W-1:0]     head;

  // count never exceeds DEPTH, so its MSB alone flags a full FIFO.
  always_comb begin
    full     = count[DEPTH_LOG2];
    empty    = (count == '0);
    head     = mem[rdPtr];
    // Line mode keeps draining once the FIFO has filled, so an unterminated
    // line cannot wedge the buffer after a single flushed byte.
    if (MODE == 2'b01)
      eligible = full || (!empty && ((lineCnt != '0) || flush));
    else
      eligible = !empty;
    push     = RX_DONE && !full;
    pop      = (state == IDLE) && eligible && !TX_VALID;
    pushTerm = push && (RX_DATA == TERM);
    popTerm  = pop && (head == TERM);
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wrPtr] <= RX_DATA;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      lineCnt  <= '0;
      flush    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({pushTerm, popTerm})
        2'b10:   lineCnt <= lineCnt + 1'b1;
        2'b01:   lineCnt <= lineCnt - 1'b1;
        default: lineCnt <= lineCnt;
      endcase
      if (full)
        flush <= 1'b1;
      else if (empty)
        flush <= 1'b0;
      if (RX_DONE && full)
        overflow <= 1'b1;
      else if (CLR_OVF)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      txEn   <= 1'b0;
      txData <= '0;
    end else begin
      txEn <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            txData <= (MODE == 2'b10) ? ~head : head;
            state  <= SEND;
          end
        end
        SEND: begin
          txEn  <= 1'b1;
          state <= TX_DONE ? IDLE : WAIT;
        end
        WAIT: begin
          if (TX_DONE)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign TXEN     = txEn;
  assign TX_DATA  = txData;
  assign LEVEL    = count;
  assign OVERFLOW = overflow;
  assign BUSY     = (state != IDLE);

endmodule

// File: tb/tb_ft245_echo_fifo.sv
// Bench for ft245_echo_fifo: directed scenarios plus random bursts, checked
// against a queue-based model of the echo behaviour.
module tb_ft245_echo_fifo;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [7:0] TERM = 8'h0D;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                RX_DONE = 1'b0;
  logic [7:0]          RX_DATA = '0;
  logic                TX_VALID = 1'b0;
  logic                TX_DONE = 1'b0;
  logic                TXEN;
  logic [7:0]          TX_DATA;
  logic [1:0]          MODE = 2'b00;
  logic                CLR_OVF = 1'b0;
  logic [DEPTH_LOG2:0] LEVEL;
  logic                OVERFLOW;
  logic                BUSY;

  ft245_echo_fifo #(.DATA_W(8), .DEPTH_LOG2(DEPTH_LOG2), .TERM(TERM)) dut (
    .CLK(CLK), .RST(RST), .RX_DONE(RX_DONE), .RX_DATA(RX_DATA),
    .TX_VALID(TX_VALID), .TX_DONE(TX_DONE), .TXEN(TXEN), .TX_DATA(TX_DATA),
    .MODE(MODE), .CLR_OVF(CLR_OVF), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int txCount = 0;
  int lastTxenCyc = 0;
  int rxCyc = 0;
  int txDoneLat = 5;
  int modeV = 0;

  logic [7:0] mdl[$];
  logic       mdlFlush = 1'b0;
  logic       expOvf = 1'b0;
  logic       holding = 1'b0;
  logic [7:0] heldData = '0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic hasTerm();
    foreach (mdl[i]) if (mdl[i] == TERM) return 1'b1;
    return 1'b0;
  endfunction

  // TX monitor: every TXEN must carry the model's next byte and hold it.
  always @(negedge CLK) begin
    logic [7:0] exp;
    if (!RST) holding = 1'b0;
    else begin
      if (TXEN) begin
        txCount++;
        lastTxenCyc = cyc;
        if (modeV == 1)
          chk("lineEligible", {31'd0, hasTerm() || (mdl.size() == DEPTH) || mdlFlush}, 1);
        chk("txenHasData", {31'd0, mdl.size() != 0}, 1);
        if (mdl.size() != 0) begin
          exp = mdl.pop_front();
          if (modeV == 2) exp = ~exp;
          chk("txData", {24'd0, TX_DATA}, {24'd0, exp});
          if (mdl.size() == 0) mdlFlush = 1'b0;
        end
        holding = 1'b1;
        heldData = TX_DATA;
      end else if (holding)
        chk("txHold", {24'd0, TX_DATA}, {24'd0, heldData});
      if (TX_DONE) holding = 1'b0;
    end
  end

  // Core model: TX_DONE pulse txDoneLat cycles after each TXEN.
  always begin
    @(negedge CLK);
    if (TXEN && RST) begin
      repeat (txDoneLat) @(posedge CLK);
      #1 TX_DONE = 1'b1;
      @(posedge CLK);
      #1 TX_DONE = 1'b0;
    end
  end

  task automatic setMode(input int m);
    modeV = m;
    MODE = 2'(m);
  endtask

  task automatic rxByte(input logic [7:0] b, input logic clr = 1'b0);
    @(posedge CLK);
    #1 RX_DONE = 1'b1;
    RX_DATA = b;
    CLR_OVF = clr;
    rxCyc = cyc;
    if (mdl.size() < DEPTH) begin
      mdl.push_back(b);
      if (mdl.size() == DEPTH) mdlFlush = 1'b1;
    end else
      expOvf = 1'b1;
    if (clr && !(mdl.size() == DEPTH && expOvf)) expOvf = 1'b0;
    @(posedge CLK);
    #1 RX_DONE = 1'b0;
    CLR_OVF = 1'b0;
  endtask

  task automatic clrOvf();
    @(posedge CLK);
    #1 CLR_OVF = 1'b1;
    expOvf = 1'b0;
    @(posedge CLK);
    #1 CLR_OVF = 1'b0;
  endtask

  task automatic waitTx(input string tag, input int target);
    for (int i = 0; i < 60 && txCount < target; i++) @(negedge CLK);
    chk(tag, txCount, target);
  endtask

  task automatic waitIdle(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (mdl.size() == 0 && !BUSY) break;
    end
    chk(tag, {31'd0, (mdl.size() == 0) && !BUSY}, 1);
    chk({tag, "_level"}, {29'd0, LEVEL}, mdl.size());
  endtask

  initial begin
    int base;
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_txen", {31'd0, TXEN}, 0);
    chk("rst_txdata", {24'd0, TX_DATA}, 0);
    chk("rst_level", {29'd0, LEVEL}, 0);
    chk("rst_ovf", {31'd0, OVERFLOW}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);

    // Byte echo with latency check
    setMode(0);
    txDoneLat = 5;
    base = txCount;
    for (int i = 0; i < 3; i++) begin
      rxByte(8'h41 + 8'(i));
      waitTx("byte_tx", base + i + 1);
      chk("byte_latency", lastTxenCyc - rxCyc, 3);
      repeat (18) @(posedge CLK);
    end
    waitIdle("byte_idle");

    // Line mode: nothing goes out until the terminator arrives
    setMode(1);
    txDoneLat = 3;
    base = txCount;
    rxByte("h");
    repeat (10) @(posedge CLK);
    chk("line_hold_h", txCount, base);
    rxByte("i");
    repeat (10) @(posedge CLK);
    chk("line_hold_i", txCount, base);
    rxByte(TERM);
    waitIdle("line_idle");
    chk("line_count", txCount, base + 3);

    // Inverted echo under backpressure
    setMode(2);
    base = txCount;
    TX_VALID = 1'b1;
    rxByte(8'h00);
    rxByte(8'hA5);
    repeat (50) @(posedge CLK);
    chk("inv_stall", txCount, base);
    chk("inv_level", {29'd0, LEVEL}, 2);
    TX_VALID = 1'b0;
    waitIdle("inv_idle");
    chk("inv_count", txCount, base + 2);

    // Overflow, clear, and set-beats-clear
    setMode(0);
    base = txCount;
    TX_VALID = 1'b1;
    for (int i = 1; i <= 5; i++) rxByte(8'(i));
    chk("ovf_level", {29'd0, LEVEL}, DEPTH);
    chk("ovf_flag", {31'd0, OVERFLOW}, {31'd0, expOvf});
    clrOvf();
    chk("ovf_clr", {31'd0, OVERFLOW}, {31'd0, expOvf});
    rxByte(8'h06, 1'b1);
    chk("ovf_set_wins", {31'd0, OVERFLOW}, {31'd0, expOvf});
    TX_VALID = 1'b0;
    waitIdle("ovf_idle");
    chk("ovf_count", txCount, base + 4);
    chk("ovf_sticky", {31'd0, OVERFLOW}, 1);
    clrOvf();
    chk("ovf_clr2", {31'd0, OVERFLOW}, 0);

    // Line mode without terminator must drain once full
    setMode(1);
    base = txCount;
    for (int i = 0; i < DEPTH; i++) rxByte(8'h30 + 8'(i));
    waitIdle("flush_idle");
    chk("flush_count", txCount, base + DEPTH);

    // Reset while waiting for TX_DONE
    setMode(0);
    txDoneLat = 30;
    TX_VALID = 1'b1;
    for (int i = 0; i < 4; i++) rxByte(8'hA0 + 8'(i));
    base = txCount;
    TX_VALID = 1'b0;
    waitTx("rst_first_tx", base + 1);
    repeat (2) @(negedge CLK);
    chk("rst_busy_wait", {31'd0, BUSY}, 1);
    chk("rst_level_wait", {29'd0, LEVEL}, 3);
    @(posedge CLK);
    #1 RST = 1'b0;
    mdl.delete();
    mdlFlush = 1'b0;
    expOvf = 1'b0;
    #1;
    chk("rstm_txen", {31'd0, TXEN}, 0);
    chk("rstm_txdata", {24'd0, TX_DATA}, 0);
    chk("rstm_level", {29'd0, LEVEL}, 0);
    chk("rstm_busy", {31'd0, BUSY}, 0);
    chk("rstm_ovf", {31'd0, OVERFLOW}, 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    base = txCount;
    repeat (40) @(posedge CLK);
    chk("rstm_quiet", txCount, base);
    txDoneLat = 2;
    rxByte(8'h77);
    waitIdle("rstm_new");
    chk("rstm_new_count", txCount, base + 1);

    // Random bursts in the non-line modes
    for (int b = 0; b < 10; b++) begin
      int m;
      int n;
      m = $urandom_range(0, 2);
      if (m == 1) m = 3;
      setMode(m);
      txDoneLat = $urandom_range(1, 6);
      base = txCount;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        rxByte(8'($urandom));
      end
      waitIdle("rand_idle");
      chk("rand_count", txCount, base + n);
    end
    chk("final_ovf", {31'd0, OVERFLOW}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
